egress_dispatcher: RTL and testbench



---
 rtl/switch_pkg.sv | 16 +
 rtl/egress_dispatcher_sync_fifo.sv | 53 +++++
 rtl/egress_dispatcher.sv | 89 ++++++++
 tb/tb_egress_dispatcher.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and widths for the switch egress path.
package switch_pkg;

   localparam int PORT_W     = 4;
   localparam int DATA_W     = 128;
   localparam int DROP_CNT_W = 16;

   typedef logic [PORT_W-1:0] port_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      port_t             src;
      port_t             dst;
   } egress_entry_t;

endpackage

// File: rtl/egress_dispatcher_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter; the caller must not
// push when full or pop when empty.
module sync_fifo #(
   parameter int W     = 136,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // NOTE: storage carries no reset; the level counter alone decides which
   // entries are meaningful, and a resettable array would cost a reset net per bit.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register sees the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/egress_dispatcher.sv
// Queues tagged words and presents the head to one of PORTS egress ports.
// Build option: EGRESS_HAIRPIN_EN forwards hairpin words instead of dropping them.
module egress_dispatcher
   import switch_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int PORTS = 16,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  port_t                   in_port,
   output logic [PORTS-1:0]        out_valid,
   input  logic [PORTS-1:0]        out_ready,
   output logic [WIDTH-1:0]        out_data,
   output port_t                   out_src,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [DROP_CNT_W-1:0]   drop_count
);

   localparam int ENTRY_W = WIDTH + 2*PORT_W;

   port_t              in_dst;
   logic               accept;
   logic               drop;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [ENTRY_W-1:0] head;
   port_t              head_dst;

   assign in_dst = in_data[WIDTH-1 -: PORT_W];
   assign accept = in_valid && in_ready;

`ifdef EGRESS_HAIRPIN_EN
   assign drop = 1'b0;
`else
   assign drop = (in_dst == in_port);
`endif

   assign push = accept && !drop;

   sync_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata ({in_data, in_port, in_dst}),
      .rdata (head),
      .level (fifo_level),
      .full  (full),
      .empty (empty)
   );

   // Full refuses input even if the head pops this cycle: no bypass path.
   assign in_ready = !full;
   assign head_dst = head[PORT_W-1:0];

   // NOTE: every output of this block gets a value on every path, so no latch
   // is inferred; the empty case forces zeros so stale storage never leaks.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      out_src   = '0;
      if (!empty) begin
         out_valid = PORTS'(1) << head_dst;
         out_data  = head[ENTRY_W-1 -: WIDTH];
         out_src   = head[2*PORT_W-1 -: PORT_W];
      end
   end

   assign pop = |(out_valid & out_ready);

   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_count <= '0;
      end else if (accept && drop && (drop_count != '1)) begin
         drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_egress_dispatcher.sv
// Randomized and directed bench for egress_dispatcher against a queue model.
module tb_egress_dispatcher;
   import switch_pkg::*;

   localparam int WIDTH = 128;
   localparam int PORTS = 16;
   localparam int DEPTH = 8;
`ifdef EGRESS_HAIRPIN_EN
   localparam bit HP_EN = 1'b1;
`else
   localparam bit HP_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   port_t              in_port;
   logic [PORTS-1:0]   out_valid;
   logic [PORTS-1:0]   out_ready;
   logic [WIDTH-1:0]   out_data;
   port_t              out_src;
   logic [3:0]         fifo_level;
   logic [15:0]        drop_count;

   egress_dispatcher #(.WIDTH(WIDTH), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_port    (in_port),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .fifo_level (fifo_level),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   egress_entry_t model_q[$];
   logic [15:0]   model_drops = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] make_data(input port_t dst);
      logic [WIDTH-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[WIDTH-1 -: 4] = dst;
      return d;
   endfunction

   // Compare every output with what the queue model says should be visible.
   task automatic check_outputs();
      logic [PORTS-1:0] exp_valid;
      exp_valid = '0;
      if (model_q.size() != 0) exp_valid[model_q[0].dst] = 1'b1;
      check("in_ready",   in_ready,   model_q.size() != DEPTH);
      check("fifo_level", fifo_level, model_q.size());
      check("out_valid",  out_valid,  exp_valid);
      check("out_data",   out_data,   model_q.size() != 0 ? model_q[0].data : '0);
      check("out_src",    out_src,    model_q.size() != 0 ? model_q[0].src  : '0);
      check("drop_count", drop_count, model_drops);
   endtask

   // Advance one clock with the inputs currently driven, update the model from
   // the rules (accept, hairpin drop, pop of the head), then compare.
   task automatic cycle();
      bit            rst, acc, hp, popd;
      egress_entry_t e;
      rst  = !reset;
      acc  = in_valid && (model_q.size() != DEPTH);
      hp   = (in_data[WIDTH-1 -: 4] == in_port) && !HP_EN;
      popd = (model_q.size() != 0) && out_ready[model_q[0].dst];
      e.data = in_data;
      e.src  = in_port;
      e.dst  = in_data[WIDTH-1 -: 4];
      @(posedge clk);
      #1;
      if (rst) begin
         model_q.delete();
         model_drops = '0;
      end else begin
         if (popd) void'(model_q.pop_front());
         if (acc) begin
            if (hp) begin
               if (model_drops != 16'hFFFF) model_drops++;
            end else begin
               model_q.push_back(e);
            end
         end
      end
      check_outputs();
   endtask

   task automatic drive(input bit v, input port_t dst, input port_t src, input logic [PORTS-1:0] rdy);
      in_valid  = v;
      in_data   = v ? make_data(dst) : 'x;
      in_port   = src;
      out_ready = rdy;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(1'b0, '0, '0, '0);
      cycle();
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_port   = '0;
      out_ready = '0;
      cycle();
      reset = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 10; i++) cycle();

      // Single word to port 5, held 5 cycles, then popped.
      drive(1'b1, 4'h5, 4'h2, '0);
      cycle();
      check("t2_valid", out_valid, 16'h0020);
      check("t2_src",   out_src,   4'h2);
      drive(1'b0, '0, '0, '0);
      for (int i = 0; i < 5; i++) cycle();
      out_ready = 16'h0020;
      cycle();
      check("t2_level", fifo_level, 0);
      out_ready = '0;

      // Fill to DEPTH; 9th word refused.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, port_t'($urandom_range(0, 15)), port_t'((i % 15) + 1), '0);
         if (in_data[WIDTH-1 -: 4] == in_port) in_port = in_port + 1'b1;
         cycle();
      end
      check("t3_ready", in_ready,   1'b0);
      check("t3_level", fifo_level, 8);

      // Full with pop and in_valid together: push refused.
      drive(1'b1, 4'h1, 4'h0, '1);
      cycle();
      check("t4_level", fifo_level, 7);
      check("t4_ready", in_ready,   1'b1);
      drive(1'b0, '0, '0, '1);
      for (int i = 0; i < 8; i++) cycle();
      check("t3_drained", fifo_level, 0);

      // Hairpin word.
      do_reset();
      drive(1'b1, 4'h3, 4'h3, '0);
      cycle();
      check("t5_valid", out_valid,  HP_EN ? 16'h0008 : 16'h0000);
      check("t5_drops", drop_count, HP_EN ? 16'd0 : 16'd1);

      // Mid-stream reset discards queued entries.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, port_t'(i + 8), port_t'(i), '0);
         cycle();
      end
      reset = 1'b0;
      drive(1'b1, 4'h9, 4'h1, '1);
      cycle();
      reset = 1'b1;
      check("t6_valid", out_valid,  0);
      check("t6_level", fifo_level, 0);
      check("t6_drops", drop_count, 0);
      drive(1'b1, 4'hC, 4'h7, '0);
      cycle();
      check("t6_head_src", out_src,   4'h7);
      check("t6_head_vld", out_valid, 16'h1000);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         port_t dst, src;
         dst = port_t'($urandom_range(0, 15));
         src = ($urandom_range(0, 5) == 0) ? dst : port_t'($urandom_range(0, 15));
         drive($urandom_range(0, 9) < 7, dst, src,
               ($urandom_range(0, 3) == 0) ? '1 : PORTS'($urandom));
         reset = ($urandom_range(0, 299) != 0);
         cycle();
      end
      reset = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
